// File: rtl/eq_cfg_pkg.sv
// Shared configuration for the equalizer amplifier gain controller.
// Holds the default build parameters, the band-index width, the controller
// state encoding and band indices in equalizer port order.
package eq_cfg_pkg;

    localparam int unsigned NUMBER_OF_FILTERS = 8;
    localparam int unsigned GAIN_BITS         = 8;
    localparam int unsigned GAIN_FRAC_BITS    = 2;   // 8.2 format: -32.0 .. +31.75
    localparam int unsigned RAMP_STEP         = 1;   // raw LSBs per sample (0.25)
    localparam int          DEFAULT_GAIN      = 4;   // raw 4 = 1.0
    localparam int unsigned BAND_IDX_BITS     = $clog2(NUMBER_OF_FILTERS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_RAMP = 2'd2
    } ctrl_state_e;

    // Band indices matching the equalizer's amplifier port order
    localparam logic [BAND_IDX_BITS-1:0] BAND_LPF_1000HZ = BAND_IDX_BITS'(0);
    localparam logic [BAND_IDX_BITS-1:0] BAND_1          = BAND_IDX_BITS'(1);
    localparam logic [BAND_IDX_BITS-1:0] BAND_2          = BAND_IDX_BITS'(2);
    localparam logic [BAND_IDX_BITS-1:0] BAND_3          = BAND_IDX_BITS'(3);
    localparam logic [BAND_IDX_BITS-1:0] BAND_4          = BAND_IDX_BITS'(4);
    localparam logic [BAND_IDX_BITS-1:0] BAND_5          = BAND_IDX_BITS'(5);
    localparam logic [BAND_IDX_BITS-1:0] BAND_6          = BAND_IDX_BITS'(6);
    localparam logic [BAND_IDX_BITS-1:0] BAND_HPF_7000HZ = BAND_IDX_BITS'(7);

endpackage

// File: rtl/gain_ramp_step.sv
// One band's ramp step: moves live toward target by at most RAMP_STEP raw LSBs.
// Ports:
//   live        current live gain (signed)
//   target      committed target gain (signed)
//   next_live_c live gain after one step (combinational)
module gain_ramp_step #(
    parameter int unsigned GAIN_BITS = eq_cfg_pkg::GAIN_BITS,
    parameter int unsigned RAMP_STEP = eq_cfg_pkg::RAMP_STEP
) (
    input  logic signed [GAIN_BITS-1:0] live,
    input  logic signed [GAIN_BITS-1:0] target,
    output logic signed [GAIN_BITS-1:0] next_live_c
);

    // One extra bit so the difference of two full-range gains cannot wrap
    localparam int unsigned DIFF_W = GAIN_BITS + 1;
    localparam logic signed [DIFF_W-1:0] STEP_POS = DIFF_W'(RAMP_STEP);
    localparam logic signed [DIFF_W-1:0] STEP_NEG = -STEP_POS;

    logic signed [DIFF_W-1:0] live_x;
    logic signed [DIFF_W-1:0] target_x;
    logic signed [DIFF_W-1:0] diff;

    assign live_x   = {live[GAIN_BITS-1], live};
    assign target_x = {target[GAIN_BITS-1], target};
    assign diff     = target_x - live_x;

    // Within one step we land exactly on target, so the result never overshoots
    always_comb begin
        next_live_c = target;
        if (diff > STEP_POS) begin
            next_live_c = GAIN_BITS'(live_x + STEP_POS);
        end else if (diff < STEP_NEG) begin
            next_live_c = GAIN_BITS'(live_x - STEP_POS);
        end
    end

endmodule

// File: rtl/eq_gain_ramp_ctrl.sv
// Equalizer amplifier gain controller: stages per-band gain writes from a host,
// commits them as targets, and ramps the live gain bus toward the targets one
// bounded step per output sample to avoid zipper noise.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   sample_tick       one-cycle pulse per equalizer output sample
//   cfg_valid/ready   host handshake; a beat is accepted when both are high
//   cfg_band/gain     band index and signed raw gain of a write
//   cfg_wr/commit     beat writes the stage register / commits stage to target
//   amplifier_gains   live gains, band i at [(i+1)*GAIN_BITS-1 : i*GAIN_BITS]
//   amplifier_enable  set by the first accepted commit, held until reset
//   ramp_busy         high while a ramp is in progress
//   cfg_err           one-cycle pulse after a write to an out-of-range band
module eq_gain_ramp_ctrl #(
    parameter  int unsigned NUMBER_OF_FILTERS = eq_cfg_pkg::NUMBER_OF_FILTERS,
    parameter  int unsigned GAIN_BITS         = eq_cfg_pkg::GAIN_BITS,
    parameter  int unsigned RAMP_STEP         = eq_cfg_pkg::RAMP_STEP,
    parameter  int          DEFAULT_GAIN      = eq_cfg_pkg::DEFAULT_GAIN,
    localparam int unsigned BAND_W            = $clog2(NUMBER_OF_FILTERS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   sample_tick,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [BAND_W-1:0]                      cfg_band,
    input  logic [GAIN_BITS-1:0]                   cfg_gain,
    input  logic                                   cfg_wr,
    input  logic                                   cfg_commit,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] amplifier_gains,
    output logic                                   amplifier_enable,
    output logic                                   ramp_busy,
    output logic                                   cfg_err
);

    import eq_cfg_pkg::*;

    typedef logic signed [GAIN_BITS-1:0] gain_t;

    localparam gain_t RESET_GAIN = GAIN_BITS'(DEFAULT_GAIN);

    ctrl_state_e state_q, state_d;

    gain_t stage_q  [NUMBER_OF_FILTERS];
    gain_t stage_d  [NUMBER_OF_FILTERS];
    gain_t target_q [NUMBER_OF_FILTERS];
    gain_t target_d [NUMBER_OF_FILTERS];
    gain_t live_q   [NUMBER_OF_FILTERS];
    gain_t live_d   [NUMBER_OF_FILTERS];
    gain_t step_live[NUMBER_OF_FILTERS];

    logic ready_q, ready_d;
    logic busy_q, busy_d;
    logic err_q, err_d;
    logic enable_q, enable_d;

    logic accept;
    logic band_ok;
    logic all_equal;

    assign accept  = cfg_valid & ready_q;
    assign band_ok = ({1'b0, cfg_band} < (BAND_W + 1)'(NUMBER_OF_FILTERS));

    // Ramp is complete when every live gain sits on its target
    always_comb begin
        all_equal = 1'b1;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (live_q[i] != target_q[i]) begin
                all_equal = 1'b0;
            end
        end
    end

    // Per-band step units and live-bus packing
    for (genvar i = 0; i < NUMBER_OF_FILTERS; i++) begin : g_band
        gain_ramp_step #(
            .GAIN_BITS (GAIN_BITS),
            .RAMP_STEP (RAMP_STEP)
        ) u_step (
            .live        (live_q[i]),
            .target      (target_q[i]),
            .next_live_c (step_live[i])
        );
        assign amplifier_gains[i*GAIN_BITS +: GAIN_BITS] = live_q[i];
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && cfg_commit) begin
                    state_d = ST_RAMP;
                end else if (accept && cfg_wr) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (accept && cfg_commit) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (all_equal) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; status flags follow the state being entered
    always_comb begin
        ready_d  = 1'b1;
        busy_d   = 1'b0;
        err_d    = accept & cfg_wr & ~band_ok;
        enable_d = enable_q | (accept & cfg_commit);
        if (state_d == ST_RAMP) begin
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // Gain datapath: write lands in stage first so a same-beat commit sees it
    always_comb begin
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            stage_d[i]  = stage_q[i];
            target_d[i] = target_q[i];
            live_d[i]   = live_q[i];
        end
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (accept && cfg_wr && band_ok && (cfg_band == BAND_W'(i))) begin
                stage_d[i] = cfg_gain;
            end
            if (accept && cfg_commit) begin
                target_d[i] = stage_d[i];
            end
            if ((state_q == ST_RAMP) && sample_tick) begin
                live_d[i] = step_live[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
                stage_q[i]  <= RESET_GAIN;
                target_q[i] <= RESET_GAIN;
                live_q[i]   <= RESET_GAIN;
            end
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
                stage_q[i]  <= stage_d[i];
                target_q[i] <= target_d[i];
                live_q[i]   <= live_d[i];
            end
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            enable_q <= enable_d;
        end
    end

    assign cfg_ready        = ready_q;
    assign ramp_busy        = busy_q;
    assign cfg_err          = err_q;
    assign amplifier_enable = enable_q;

endmodule

// File: tb/tb_eq_gain_ramp_ctrl.sv
// Directed bench for eq_gain_ramp_ctrl: a default build (8 bands, step 1) and a
// 10-band build with step 4 share clock and reset; expected gain buses come
// from a behavioural model through per-instance scoreboard queues.
module tb_eq_gain_ramp_ctrl;

    localparam int unsigned GB     = 8;
    localparam int unsigned N_A    = 8;
    localparam int unsigned STEP_A = 1;
    localparam int unsigned N_B    = 10;
    localparam int unsigned STEP_B = 4;
    localparam int          DEF    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b0;

    // Instance A (default build)
    logic               tick_a = 1'b0, valid_a = 1'b0, wr_a = 1'b0, commit_a = 1'b0;
    logic [2:0]         band_a = '0;
    logic [GB-1:0]      gain_a = '0;
    logic               ready_a, en_a, busy_a, err_a;
    logic [N_A*GB-1:0]  gains_a;

    // Instance B (10 bands, step 4)
    logic               tick_b = 1'b0, valid_b = 1'b0, wr_b = 1'b0, commit_b = 1'b0;
    logic [3:0]         band_b = '0;
    logic [GB-1:0]      gain_b = '0;
    logic               ready_b, en_b, busy_b, err_b;
    logic [N_B*GB-1:0]  gains_b;

    eq_gain_ramp_ctrl u_dut (
        .clk(clk), .rst(rst), .sample_tick(tick_a), .cfg_valid(valid_a),
        .cfg_ready(ready_a), .cfg_band(band_a), .cfg_gain(gain_a), .cfg_wr(wr_a),
        .cfg_commit(commit_a), .amplifier_gains(gains_a), .amplifier_enable(en_a),
        .ramp_busy(busy_a), .cfg_err(err_a)
    );

    eq_gain_ramp_ctrl #(.NUMBER_OF_FILTERS(N_B), .RAMP_STEP(STEP_B)) u_wide (
        .clk(clk), .rst(rst), .sample_tick(tick_b), .cfg_valid(valid_b),
        .cfg_ready(ready_b), .cfg_band(band_b), .cfg_gain(gain_b), .cfg_wr(wr_b),
        .cfg_commit(commit_b), .amplifier_gains(gains_b), .amplifier_enable(en_b),
        .ramp_busy(busy_b), .cfg_err(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_stage_a[N_A], m_tgt_a[N_A], m_live_a[N_A];
    int m_stage_b[N_B], m_tgt_b[N_B], m_live_b[N_B];
    logic [N_A*GB-1:0] exp_q_a[$];
    logic [N_B*GB-1:0] exp_q_b[$];

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int step_toward(input int l, input int t, input int s);
        if (t > l) return (t - l > s) ? l + s : t;
        return (l - t > s) ? l - s : t;
    endfunction

    function automatic logic [N_A*GB-1:0] pack_a();
        logic [N_A*GB-1:0] v;
        for (int i = 0; i < N_A; i++) v[i*GB +: GB] = GB'(m_live_a[i]);
        return v;
    endfunction

    function automatic logic [N_B*GB-1:0] pack_b();
        logic [N_B*GB-1:0] v;
        for (int i = 0; i < N_B; i++) v[i*GB +: GB] = GB'(m_live_b[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_A; i++) begin
            m_stage_a[i] = DEF; m_tgt_a[i] = DEF; m_live_a[i] = DEF;
        end
        for (int i = 0; i < N_B; i++) begin
            m_stage_b[i] = DEF; m_tgt_b[i] = DEF; m_live_b[i] = DEF;
        end
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One accepted beat on instance A; optional tick in the same cycle
    task automatic beat_a(input logic wr, input logic cm, input int band, input int gain,
                          input logic tick);
        valid_a = 1'b1; wr_a = wr; commit_a = cm; band_a = 3'(band); gain_a = GB'(gain);
        tick_a = tick;
        cyc(1);
        valid_a = 1'b0; wr_a = 1'b0; commit_a = 1'b0; tick_a = 1'b0;
        if (wr && band < int'(N_A)) m_stage_a[band] = gain;
        if (cm) for (int i = 0; i < N_A; i++) m_tgt_a[i] = m_stage_a[i];
    endtask

    task automatic beat_b(input logic wr, input logic cm, input int band, input int gain);
        valid_b = 1'b1; wr_b = wr; commit_b = cm; band_b = 4'(band); gain_b = GB'(gain);
        cyc(1);
        valid_b = 1'b0; wr_b = 1'b0; commit_b = 1'b0;
        if (wr && band < int'(N_B)) m_stage_b[band] = gain;
        if (cm) for (int i = 0; i < N_B; i++) m_tgt_b[i] = m_stage_b[i];
    endtask

    // Ramp tick: model steps and pushes, DUT bus is popped and compared after the edge
    task automatic tick_step_a();
        for (int i = 0; i < N_A; i++) m_live_a[i] = step_toward(m_live_a[i], m_tgt_a[i], STEP_A);
        exp_q_a.push_back(pack_a());
        tick_a = 1'b1;
        cyc(1);
        tick_a = 1'b0;
        check("gains_a_tick", 80'(gains_a), 80'(exp_q_a.pop_front()));
    endtask

    task automatic tick_step_b();
        for (int i = 0; i < N_B; i++) m_live_b[i] = step_toward(m_live_b[i], m_tgt_b[i], STEP_B);
        exp_q_b.push_back(pack_b());
        tick_b = 1'b1;
        cyc(1);
        tick_b = 1'b0;
        check("gains_b_tick", 80'(gains_b), 80'(exp_q_b.pop_front()));
    endtask

    initial begin
        model_reset();

        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gains", 80'(gains_a), 80'(64'h0404_0404_0404_0404));
        check("rst_ready", 80'(ready_a), 80'(1'b0));
        check("rst_enable", 80'(en_a), 80'(1'b0));
        check("rst_busy", 80'(busy_a), 80'(1'b0));
        check("rst_err", 80'(err_a), 80'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        check("rel_gains", 80'(gains_a), 80'(64'h0404_0404_0404_0404));
        check("rel_ready", 80'(ready_a), 80'(1'b1));
        check("rel_busy", 80'(busy_a), 80'(1'b0));
        check("rel_enable", 80'(en_a), 80'(1'b0));

        // Band 3 = 8 then separate commit: steps 5,6,7,8
        beat_a(1'b1, 1'b0, 3, 8, 1'b0);
        check("pend_ready", 80'(ready_a), 80'(1'b1));
        check("pend_enable", 80'(en_a), 80'(1'b0));
        beat_a(1'b0, 1'b1, 0, 0, 1'b0);
        check("commit_busy", 80'(busy_a), 80'(1'b1));
        check("commit_ready", 80'(ready_a), 80'(1'b0));
        check("commit_enable", 80'(en_a), 80'(1'b1));
        check("commit_gains", 80'(gains_a), 80'(pack_a()));
        tick_step_a();
        cyc(1);
        check("no_tick_hold", 80'(gains_a), 80'(pack_a()));
        tick_step_a();
        tick_step_a();
        tick_step_a();
        check("b3_final", 80'(gains_a), 80'(64'h0404_0404_0804_0404));
        check("b3_busy_hold", 80'(busy_a), 80'(1'b1));
        cyc(1);
        check("b3_busy_fall", 80'(busy_a), 80'(1'b0));
        check("b3_ready_back", 80'(ready_a), 80'(1'b1));

        // Wide build: band 7 = -8, band 9 = 20, band 12 out of range
        check("b_ready", 80'(ready_b), 80'(1'b1));
        beat_b(1'b1, 1'b0, 7, -8);
        check("b_err_legal7", 80'(err_b), 80'(1'b0));
        beat_b(1'b1, 1'b0, 9, 20);
        check("b_err_legal9", 80'(err_b), 80'(1'b0));
        beat_b(1'b1, 1'b0, 12, 55);
        check("b_err_pulse", 80'(err_b), 80'(1'b1));
        cyc(1);
        check("b_err_clear", 80'(err_b), 80'(1'b0));
        check("b_gains_pre", 80'(gains_b), 80'(pack_b()));
        beat_b(1'b0, 1'b1, 0, 0);
        check("b_busy", 80'(busy_b), 80'(1'b1));
        tick_step_b();
        tick_step_b();
        tick_step_b();
        check("b_band7_f8", 80'(gains_b[63:56]), 80'(8'hF8));
        tick_step_b();
        check("b_final", 80'(gains_b), 80'h1404_F804_0404_0404_0404);
        cyc(1);
        check("b_busy_fall", 80'(busy_b), 80'(1'b0));

        // Single beat write band 0 = 12 + commit with a tick in the same cycle
        check("wc_ready", 80'(ready_a), 80'(1'b1));
        beat_a(1'b1, 1'b1, 0, 12, 1'b1);
        check("wc_no_step", 80'(gains_a), 80'(pack_a()));
        check("wc_busy", 80'(busy_a), 80'(1'b1));
        // Host attempt during RAMP must not be accepted
        valid_a = 1'b1; wr_a = 1'b1; band_a = 3'd0; gain_a = 8'd99;
        cyc(1);
        check("ramp_ready0", 80'(ready_a), 80'(1'b0));
        cyc(1);
        check("ramp_ready1", 80'(ready_a), 80'(1'b0));
        valid_a = 1'b0; wr_a = 1'b0;
        for (int k = 0; k < 8; k++) tick_step_a();
        check("wc_final", 80'(gains_a), 80'(64'h0404_0404_0804_040C));
        cyc(1);
        check("wc_busy_fall", 80'(busy_a), 80'(1'b0));
        // Commit with no staged change: RAMP then IDLE without a tick
        beat_a(1'b0, 1'b1, 0, 0, 1'b0);
        check("nochg_busy", 80'(busy_a), 80'(1'b1));
        cyc(1);
        check("nochg_busy_fall", 80'(busy_a), 80'(1'b0));
        check("nochg_ready", 80'(ready_a), 80'(1'b1));
        check("nochg_gains", 80'(gains_a), 80'(64'h0404_0404_0804_040C));

        // Reset in the middle of a 4 -> 127 ramp
        beat_a(1'b1, 1'b0, 5, 127, 1'b0);
        beat_a(1'b0, 1'b1, 0, 0, 1'b0);
        tick_step_a();
        tick_step_a();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_gains", 80'(gains_a), 80'(64'h0404_0404_0404_0404));
        check("mid_rst_enable", 80'(en_a), 80'(1'b0));
        check("mid_rst_busy", 80'(busy_a), 80'(1'b0));
        check("mid_rst_ready", 80'(ready_a), 80'(1'b0));
        check("mid_rst_gains_b", 80'(gains_b), 80'h0404_0404_0404_0404_0404);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1);
        check("post_rst_ready", 80'(ready_a), 80'(1'b1));
        check("post_rst_busy", 80'(busy_a), 80'(1'b0));
        // Stage was cleared too: an empty commit changes nothing
        beat_a(1'b0, 1'b1, 0, 0, 1'b0);
        check("post_rst_commit_busy", 80'(busy_a), 80'(1'b1));
        cyc(1);
        check("post_rst_commit_fall", 80'(busy_a), 80'(1'b0));
        check("post_rst_gains", 80'(gains_a), 80'(pack_a()));
        check("post_rst_enable", 80'(en_a), 80'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
